// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I data-side load/store initiator for port1 of a byte-addressed sram.
// One request in flight; IDLE -> ACCESS -> RESP, or IDLE -> RESP when the request faults.
module load_store_unit #(
  parameter int REGISTER_WIDTH   = 32,
  parameter int MEM_DEPTH        = 4096,
  parameter int ALLOW_MISALIGNED = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [2:0]                req_funct3,
  input  logic [REGISTER_WIDTH-1:0] req_address,
  input  logic [REGISTER_WIDTH-1:0] req_write_data,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [REGISTER_WIDTH-1:0] resp_read_data,
  output logic [1:0]                resp_fault,
  output logic                      port1_write_en,
  output logic [REGISTER_WIDTH-1:0] port1_write_data,
  output logic [REGISTER_WIDTH-1:0] port1_address,
  output logic [3:0]                port1_byte_enable,
  input  logic [REGISTER_WIDTH-1:0] port1_read_data
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  localparam logic [1:0] F_OK      = 2'd0;
  localparam logic [1:0] F_MISALGN = 2'd1;
  localparam logic [1:0] F_FUNCT3  = 2'd2;
  localparam logic [1:0] F_RANGE   = 2'd3;

  logic [1:0]                r_state;
  logic                      r_write;
  logic [2:0]                r_funct3;
  logic [1:0]                r_fault;
  logic [REGISTER_WIDTH-1:0] r_read_data;
  logic                      r_write_en;
  logic [3:0]                r_byte_enable;
  logic [REGISTER_WIDTH-1:0] r_address;
  logic [REGISTER_WIDTH-1:0] r_write_data;

  logic [2:0]                w_size;
  logic [3:0]                w_byte_enable;
  logic                      w_funct3_illegal;
  logic                      w_misaligned;
  logic [REGISTER_WIDTH:0]   w_end_address;
  logic                      w_out_of_range;
  logic [1:0]                w_fault;
  logic [REGISTER_WIDTH-1:0] w_load_data;

  assign req_ready         = (r_state == S_IDLE);
  assign resp_valid        = (r_state == S_RESP);
  assign resp_read_data    = r_read_data;
  assign resp_fault        = r_fault;
  assign port1_write_en    = r_write_en;
  assign port1_byte_enable = r_byte_enable;
  assign port1_address     = r_address;
  assign port1_write_data  = r_write_data;

  always_comb begin
    w_size        = 3'd4;
    w_byte_enable = 4'b1111;
    case (req_funct3[1:0])
      2'b00: begin w_size = 3'd1; w_byte_enable = 4'b0001; end
      2'b01: begin w_size = 3'd2; w_byte_enable = 4'b0011; end
      default: begin w_size = 3'd4; w_byte_enable = 4'b1111; end
    endcase
  end

  always_comb begin
    if (req_write) begin
      w_funct3_illegal = req_funct3[2] || (req_funct3[1:0] == 2'b11);
    end else begin
      w_funct3_illegal = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                         (req_funct3 == 3'b111);
    end
  end

  // The sram is byte-granular, so misalignment is a policy check only.
  assign w_misaligned = (ALLOW_MISALIGNED == 0) &&
                        (((req_funct3[1:0] == 2'b01) && req_address[0]) ||
                         ((req_funct3[1:0] == 2'b10) && (req_address[1:0] != 2'b00)));

  // One extra bit so an access near the top of the address space cannot wrap into range.
  assign w_end_address  = {1'b0, req_address} + {{(REGISTER_WIDTH-2){1'b0}}, w_size};
  assign w_out_of_range = w_end_address > (REGISTER_WIDTH+1)'(MEM_DEPTH);

  always_comb begin
    w_fault = F_OK;
    if (w_funct3_illegal) begin
      w_fault = F_FUNCT3;
    end else if (w_misaligned) begin
      w_fault = F_MISALGN;
    end else if (w_out_of_range) begin
      w_fault = F_RANGE;
    end
  end

  always_comb begin
    w_load_data = port1_read_data;
    case (r_funct3)
      3'b000: w_load_data = {{24{port1_read_data[7]}}, port1_read_data[7:0]};
      3'b100: w_load_data = {24'd0, port1_read_data[7:0]};
      3'b001: w_load_data = {{16{port1_read_data[15]}}, port1_read_data[15:0]};
      3'b101: w_load_data = {16'd0, port1_read_data[15:0]};
      default: w_load_data = port1_read_data;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_write       <= 1'b0;
      r_funct3      <= 3'd0;
      r_fault       <= F_OK;
      r_read_data   <= '0;
      r_write_en    <= 1'b0;
      r_byte_enable <= 4'd0;
      r_address     <= '0;
      r_write_data  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_write  <= req_write;
            r_funct3 <= req_funct3;
            r_fault  <= w_fault;
            if (w_fault != F_OK) begin
              r_read_data <= '0;
              r_state     <= S_RESP;
            end else begin
              r_address <= req_address;
              if (req_write) begin
                r_write_en    <= 1'b1;
                r_byte_enable <= w_byte_enable;
                r_write_data  <= req_write_data;
              end
              r_state <= S_ACCESS;
            end
          end
        end
        S_ACCESS: begin
          // The sram read is combinational, so load data is sampled on the edge ending ACCESS.
          r_write_en    <= 1'b0;
          r_byte_enable <= 4'd0;
          r_read_data   <= r_write ? '0 : w_load_data;
          r_state       <= S_RESP;
        end
        S_RESP: begin
          if (resp_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed, table-driven bench for load_store_unit with an sram model.
module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_address, req_write_data;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_read_data;
  logic [1:0]  resp_fault;
  logic        port1_write_en;
  logic [31:0] port1_write_data, port1_address, port1_read_data;
  logic [3:0]  port1_byte_enable;

  logic        m_req_valid, m_req_ready, m_req_write;
  logic [2:0]  m_req_funct3;
  logic [31:0] m_req_address, m_req_write_data;
  logic        m_resp_valid, m_resp_ready;
  logic [31:0] m_resp_read_data;
  logic [1:0]  m_resp_fault;
  logic        m_write_en;
  logic [31:0] m_write_data, m_address, m_read_data;
  logic [3:0]  m_byte_enable;

  int n_cmp;
  int n_err;

  logic [7:0]  mem [0:4095];
  logic [11:0] a0;

  load_store_unit dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_address(req_address), .req_write_data(req_write_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_read_data(resp_read_data),
    .resp_fault(resp_fault), .port1_write_en(port1_write_en),
    .port1_write_data(port1_write_data), .port1_address(port1_address),
    .port1_byte_enable(port1_byte_enable), .port1_read_data(port1_read_data)
  );

  load_store_unit #(.ALLOW_MISALIGNED(1)) dut_mis (
    .clk(clk), .rst(rst),
    .req_valid(m_req_valid), .req_ready(m_req_ready), .req_write(m_req_write),
    .req_funct3(m_req_funct3), .req_address(m_req_address), .req_write_data(m_req_write_data),
    .resp_valid(m_resp_valid), .resp_ready(m_resp_ready), .resp_read_data(m_resp_read_data),
    .resp_fault(m_resp_fault), .port1_write_en(m_write_en),
    .port1_write_data(m_write_data), .port1_address(m_address),
    .port1_byte_enable(m_byte_enable), .port1_read_data(m_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign a0 = port1_address[11:0];
  assign port1_read_data = {mem[a0 + 12'd3], mem[a0 + 12'd2], mem[a0 + 12'd1], mem[a0]};
  assign m_read_data = 32'h87654321;

  always @(posedge clk) begin
    if (port1_write_en) begin
      for (int i = 0; i < 4; i++) begin
        if (port1_byte_enable[i]) mem[a0 + 12'(i)] <= port1_write_data[8*i +: 8];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic run_req(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, output logic [31:0] data,
                         output logic [1:0] flt, output int lat, output int wes,
                         output logic [3:0] be, output logic [31:0] acc_addr);
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_address = addr; req_write_data = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0; wes = 0; be = 4'd0; acc_addr = 32'd0;
    for (int c = 1; c <= 20; c++) begin
      if (port1_write_en) wes++;
      be = be | port1_byte_enable;
      if (resp_valid) begin lat = c; break; end
      acc_addr = port1_address;
      @(posedge clk); #1;
    end
    data = resp_read_data;
    flt  = resp_fault;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic run_mis(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                         output logic [31:0] data, output logic [1:0] flt,
                         output int lat, output int wes);
    @(negedge clk);
    m_req_valid = 1'b1; m_req_write = wr; m_req_funct3 = f3; m_req_address = addr;
    m_req_write_data = 32'hA5A5A5A5;
    @(posedge clk); #1;
    m_req_valid = 1'b0;
    lat = 0; wes = 0;
    for (int c = 1; c <= 20; c++) begin
      if (m_write_en) wes++;
      if (m_resp_valid) begin lat = c; break; end
      @(posedge clk); #1;
    end
    data = m_resp_read_data;
    flt  = m_resp_fault;
    m_resp_ready = 1'b1;
    @(posedge clk); #1;
    m_resp_ready = 1'b0;
  endtask

  typedef struct {
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_d;
    logic [1:0]  exp_f;
    int          exp_lat;
    int          exp_we;
    logic [3:0]  exp_be;
  } vec_t;

  vec_t        v [20];
  logic [31:0] d, aa;
  logic [1:0]  f;
  int          lat, wes;
  logic [3:0]  be;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0; n_err = 0;
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    mem[12'h021] = 8'h80;
    rst = 1'b1;
    req_valid = 0; req_write = 0; req_funct3 = 0; req_address = 0; req_write_data = 0;
    resp_ready = 0;
    m_req_valid = 0; m_req_write = 0; m_req_funct3 = 0; m_req_address = 0;
    m_req_write_data = 0; m_resp_ready = 0;

    v[0]  = '{1'b1, 3'b010, 32'h10,       32'hDEADBEEF, 32'h00000000, 2'd0, 2, 1, 4'hF};
    v[1]  = '{1'b0, 3'b010, 32'h10,       32'h0,        32'hDEADBEEF, 2'd0, 2, 0, 4'h0};
    v[2]  = '{1'b0, 3'b000, 32'h21,       32'h0,        32'hFFFFFF80, 2'd0, 2, 0, 4'h0};
    v[3]  = '{1'b0, 3'b100, 32'h21,       32'h0,        32'h00000080, 2'd0, 2, 0, 4'h0};
    v[4]  = '{1'b1, 3'b001, 32'h22,       32'h1234ABCD, 32'h00000000, 2'd0, 2, 1, 4'h3};
    v[5]  = '{1'b0, 3'b101, 32'h22,       32'h0,        32'h0000ABCD, 2'd0, 2, 0, 4'h0};
    v[6]  = '{1'b0, 3'b001, 32'h22,       32'h0,        32'hFFFFABCD, 2'd0, 2, 0, 4'h0};
    v[7]  = '{1'b1, 3'b000, 32'h20,       32'h000000A5, 32'h00000000, 2'd0, 2, 1, 4'h1};
    v[8]  = '{1'b0, 3'b010, 32'h20,       32'h0,        32'hABCD80A5, 2'd0, 2, 0, 4'h0};
    v[9]  = '{1'b0, 3'b010, 32'h13,       32'h0,        32'h00000000, 2'd1, 1, 0, 4'h0};
    v[10] = '{1'b0, 3'b011, 32'h10,       32'h0,        32'h00000000, 2'd2, 1, 0, 4'h0};
    v[11] = '{1'b1, 3'b100, 32'h13,       32'h55,       32'h00000000, 2'd2, 1, 0, 4'h0};
    v[12] = '{1'b1, 3'b010, 32'hFFC,      32'h11223344, 32'h00000000, 2'd0, 2, 1, 4'hF};
    v[13] = '{1'b0, 3'b010, 32'hFFC,      32'h0,        32'h11223344, 2'd0, 2, 0, 4'h0};
    v[14] = '{1'b0, 3'b010, 32'hFFFFFFFC, 32'h0,        32'h00000000, 2'd3, 1, 0, 4'h0};
    v[15] = '{1'b1, 3'b010, 32'hFFE,      32'h77,       32'h00000000, 2'd1, 1, 0, 4'h0};
    v[16] = '{1'b0, 3'b001, 32'hFFF,      32'h0,        32'h00000000, 2'd1, 1, 0, 4'h0};
    v[17] = '{1'b0, 3'b100, 32'hFFF,      32'h0,        32'h00000011, 2'd0, 2, 0, 4'h0};
    v[18] = '{1'b0, 3'b000, 32'h1000,     32'h0,        32'h00000000, 2'd3, 1, 0, 4'h0};
    v[19] = '{1'b1, 3'b011, 32'h10,       32'h99,       32'h00000000, 2'd2, 1, 0, 4'h0};

    #3;
    chk("reset_req_ready", {31'd0, req_ready}, 32'd1);
    chk("reset_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("reset_resp_data", resp_read_data, 32'd0);
    chk("reset_resp_fault", {30'd0, resp_fault}, 32'd0);
    chk("reset_write_en", {31'd0, port1_write_en}, 32'd0);
    chk("reset_be", {28'd0, port1_byte_enable}, 32'd0);
    chk("reset_addr", port1_address, 32'd0);
    chk("reset_wdata", port1_write_data, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      run_req(v[i].wr, v[i].f3, v[i].addr, v[i].wd, d, f, lat, wes, be, aa);
      chk($sformatf("v%0d_data", i), d, v[i].exp_d);
      chk($sformatf("v%0d_fault", i), {30'd0, f}, {30'd0, v[i].exp_f});
      chk($sformatf("v%0d_latency", i), lat, v[i].exp_lat);
      chk($sformatf("v%0d_write_cycles", i), wes, v[i].exp_we);
      chk($sformatf("v%0d_be", i), {28'd0, be}, {28'd0, v[i].exp_be});
      if (v[i].exp_f == 2'd0) chk($sformatf("v%0d_addr", i), aa, v[i].addr);
    end

    // Response back-pressure: outputs hold and a new request is ignored.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010; req_address = 32'h10;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b010; req_address = 32'h10;
    req_write_data = 32'h0BADF00D;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("stall%0d_resp_valid", c), {31'd0, resp_valid}, 32'd1);
      chk($sformatf("stall%0d_data", c), resp_read_data, 32'hDEADBEEF);
      chk($sformatf("stall%0d_req_ready", c), {31'd0, req_ready}, 32'd0);
      chk($sformatf("stall%0d_write_en", c), {31'd0, port1_write_en}, 32'd0);
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk("stall_release_req_ready", {31'd0, req_ready}, 32'd1);
    chk("stall_release_resp_valid", {31'd0, resp_valid}, 32'd0);
    run_req(1'b0, 3'b010, 32'h10, 32'h0, d, f, lat, wes, be, aa);
    chk("stall_mem_intact", d, 32'hDEADBEEF);

    // Reset while a store is in its ACCESS cycle.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b010; req_address = 32'h30;
    req_write_data = 32'hCAFEF00D;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rst_pre_write_en", {31'd0, port1_write_en}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_write_en", {31'd0, port1_write_en}, 32'd0);
    chk("rst_be", {28'd0, port1_byte_enable}, 32'd0);
    chk("rst_addr", port1_address, 32'd0);
    chk("rst_wdata", port1_write_data, 32'd0);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mem_unchanged", {24'd0, mem[12'h030]}, 32'd0);
    run_req(1'b0, 3'b010, 32'h10, 32'h0, d, f, lat, wes, be, aa);
    chk("post_rst_data", d, 32'hDEADBEEF);
    chk("post_rst_latency", lat, 2);

    // ALLOW_MISALIGNED=1 instance: range check still applies, unaligned accesses proceed.
    run_mis(1'b1, 3'b010, 32'hFFE, d, f, lat, wes);
    chk("mis_sw_ffe_fault", {30'd0, f}, 32'd3);
    chk("mis_sw_ffe_latency", lat, 1);
    chk("mis_sw_ffe_write_cycles", wes, 0);
    run_mis(1'b0, 3'b010, 32'h11, d, f, lat, wes);
    chk("mis_lw_11_fault", {30'd0, f}, 32'd0);
    chk("mis_lw_11_data", d, 32'h87654321);
    chk("mis_lw_11_latency", lat, 2);
    run_mis(1'b0, 3'b001, 32'h13, d, f, lat, wes);
    chk("mis_lh_13_data", d, 32'h00004321);
    run_mis(1'b1, 3'b001, 32'h11, d, f, lat, wes);
    chk("mis_sh_11_write_cycles", wes, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
